// File: rtl/i_o_output_fifo.sv
// i_o_output_fifo: byte FIFO feeding the UART output controller.
// Bytes drain one at a time through a trigger/ready handshake.
module i_o_output_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          write_value,
   input  logic                write_trigger,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count,
   output logic                overflow,
   output logic                busy,
   output logic [7:0]          io_output_value,
   output logic                io_output_trigger,
   input  logic                io_output_ready_trigger
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            val_q, val_d;
   logic                  trig_q, trig_d;
   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];
   logic                  pop;
   logic                  accept;

   always_comb begin
      pop = (state_q == S_IDLE) && (count_q != '0)
            && io_output_ready_trigger;
      // A pop on the same edge frees the slot a full FIFO needs
      accept = write_trigger && ((count_q != CNT_FULL) || pop);

      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      val_d    = val_q;
      trig_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d  = S_SEND;
               trig_d   = 1'b1;
               val_d    = mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
         end
         S_SEND: state_d = S_WAIT;
         S_WAIT: begin
            if (!io_output_ready_trigger) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      mem_d    = mem_q;
      if (accept) begin
         mem_d[wr_ptr_q] = write_value;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else if (write_trigger) begin
         ovf_d = 1'b1;
      end

      count_d = count_q;
      if (accept && !pop) count_d = count_q + CNT_ONE;
      if (pop && !accept) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         val_q    <= 8'h00;
         trig_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         val_q    <= val_d;
         trig_q   <= trig_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign full              = (count_q == CNT_FULL);
   assign empty             = (count_q == '0);
   assign count             = count_q;
   assign overflow          = ovf_q;
   assign busy              = (count_q != '0) || (state_q != S_IDLE);
   assign io_output_value   = val_q;
   assign io_output_trigger = trig_q;

endmodule

// File: tb/tb_i_o_output_fifo.sv
// tb_i_o_output_fifo: random and directed traffic against a queue model
// of the FIFO, with a behavioural UART controller driving ready.
module tb_i_o_output_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 1 << DL2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   write_value = 8'h00;
   logic         write_trigger = 1'b0;
   logic         full, empty, overflow, busy;
   logic [DL2:0] count;
   logic [7:0]   io_output_value;
   logic         io_output_trigger;
   logic         io_output_ready_trigger = 1'b1;

   i_o_output_fifo #(.DEPTH_LOG2(DL2)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .write_value             (write_value),
      .write_trigger           (write_trigger),
      .full                    (full),
      .empty                   (empty),
      .count                   (count),
      .overflow                (overflow),
      .busy                    (busy),
      .io_output_value         (io_output_value),
      .io_output_trigger       (io_output_trigger),
      .io_output_ready_trigger (io_output_ready_trigger)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model
   logic [7:0] q[$];
   int         ph = 0;
   logic [7:0] e_val = 8'h00;
   bit         e_trig = 0;
   bit         e_ovf = 0;

   // controller model
   bit ready_m = 1;
   bit hold = 0;
   int busy_cnt = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("trigger", int'(io_output_trigger), int'(e_trig));
      chk("value", int'(io_output_value), int'(e_val));
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(e_ovf));
      chk("busy", int'(busy), int'(q.size() != 0 || ph != 0));
   endtask

   task automatic ctrl_tick(input bit trig_seen);
      if (hold) ready_m = 0;
      else if (busy_cnt > 0) begin
         busy_cnt--;
         ready_m = (busy_cnt == 0);
      end else if (trig_seen) begin
         busy_cnt = $urandom_range(6, 2);
         ready_m = 0;
      end else ready_m = 1;
   endtask

   task automatic model_reset();
      q.delete();
      ph = 0;
      e_val = 8'h00;
      e_trig = 0;
      e_ovf = 0;
   endtask

   task automatic step(input bit wr, input logic [7:0] d);
      bit pop, acc, rdy, trig_pre;
      write_trigger = wr;
      write_value = d;
      io_output_ready_trigger = ready_m;
      rdy = ready_m;
      trig_pre = io_output_trigger;
      @(posedge clk);
      pop = (ph == 0) && (q.size() > 0) && rdy;
      acc = wr && (q.size() < DEPTH || pop);
      if (pop) begin
         e_val = q.pop_front();
         e_trig = 1;
         ph = 1;
      end else begin
         e_trig = 0;
         if (ph == 1) ph = 2;
         else if (ph == 2 && !rdy) ph = 0;
      end
      if (acc) q.push_back(d);
      else if (wr) e_ovf = 1;
      ctrl_tick(trig_pre);
      #1;
      chk_all();
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || ph != 0) && n < 2000) begin
         step(0, 8'h00);
         n++;
      end
      chk("drain_done", int'(n < 2000), 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1;
      model_reset();
      #1;
      chk_all();
      @(posedge clk);
      ctrl_tick(0);
      #1;
      reset = 0;
      chk_all();
   endtask

   initial begin
      int n;
      // reset values
      #3;
      chk_all();
      @(posedge clk);
      #1;
      reset = 0;
      chk_all();

      // single byte, 2-edge latency
      step(1, 8'hAA);
      step(0, 8'h00);
      chk("single_trig", int'(io_output_trigger), 1);
      chk("single_val", int'(io_output_value), 8'hAA);
      drain();

      // burst ordering
      step(1, 8'h01);
      step(1, 8'h02);
      step(1, 8'h03);
      drain();

      // full and overflow with ready held low
      hold = 1;
      step(0, 8'h00);
      for (int i = 0; i < 17; i++) step(1, 8'(8'h10 + i));
      chk("full_after_17", int'(full), 1);
      chk("ovf_after_17", int'(overflow), 1);
      hold = 0;
      drain();

      // push while full, coinciding with a pop
      do_reset();
      hold = 1;
      step(0, 8'h00);
      for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i));
      chk("full16", int'(count), 16);
      hold = 0;
      n = 0;
      while (!ready_m && n < 50) begin
         step(0, 8'h00);
         n++;
      end
      step(1, 8'h99);
      chk("push_pop_count", int'(count), 16);
      chk("push_pop_ovf", int'(overflow), 0);
      drain();

      // pointer wrap: 40 bytes in batches of 10
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 10; i++) step(1, 8'($urandom));
         drain();
      end
      chk("wrap_count", int'(count), 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 0) hold = ($urandom_range(1, 0) == 1);
         if (i % 150 == 40) hold = 0;
         step($urandom_range(3, 0) != 0, 8'($urandom));
      end
      hold = 0;
      drain();

      // async reset mid-drain with bytes queued
      for (int i = 0; i < 8; i++) step(1, 8'(8'hC0 + i));
      n = 0;
      while (!(io_output_trigger && q.size() >= 5) && n < 200) begin
         step(0, 8'h00);
         n++;
      end
      chk("trig_reached", int'(n < 200), 1);
      #2;
      reset = 1;
      model_reset();
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_trig", int'(io_output_trigger), 0);
      @(posedge clk);
      ctrl_tick(0);
      #1;
      reset = 0;
      for (int i = 0; i < 15; i++) step(0, 8'h00);
      step(1, 8'h5A);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
